// File: rtl/rr_arbiter.sv
// Round-robin arbiter with held grants, presenting the owner as a
// registered binary index plus valid for a downstream one-hot decoder.
module rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_v
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] idx_inc;
    logic             found;
    logic             release_c;

    // Scan ptr, ptr+1, ... modulo NUM_REQ; first set bit wins.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

    assign idx_inc = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                         : grant_idx + 1'b1;

    // A done pulse and an owner request drop together are one release.
    assign release_c = done | ~req[grant_idx];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = grant_idx;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    idx_nxt   = win;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_nxt = IDLE;
                    ptr_nxt   = idx_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant_idx <= idx_nxt;
        end
    end

    assign grant_v = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: an 8-requester and a 5-requester
// instance, directed grant sequences checked by per-instance monitors.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req8;
    logic       done8;
    logic [2:0] grant_idx8;
    logic       grant_v8;
    logic [4:0] req5;
    logic       done5;
    logic [2:0] grant_idx5;
    logic       grant_v5;

    int checks;
    int passes;
    int q8[$];
    int q5[$];

    logic       pv8;
    logic [2:0] pidx8;
    logic       pv5;
    logic [2:0] pidx5;

    rr_arbiter #(.NUM_REQ(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .req       (req8),
        .done      (done8),
        .grant_idx (grant_idx8),
        .grant_v   (grant_v8)
    );

    rr_arbiter #(.NUM_REQ(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .req       (req5),
        .done      (done5),
        .grant_idx (grant_idx5),
        .grant_v   (grant_v5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // New grants pop the scoreboard; held grants must keep their index.
    always @(negedge clk) begin
        if (rst) begin
            pv8 = 1'b0;
        end else begin
            if (grant_v8 && !pv8) begin
                if (q8.size() == 0) begin
                    chk("grant8_unexpected", int'(grant_idx8), -1);
                end else begin
                    chk("grant8_idx", int'(grant_idx8), q8.pop_front());
                end
            end else if (grant_v8 && pv8) begin
                chk("grant8_hold", int'(grant_idx8), int'(pidx8));
            end
            pv8   = grant_v8;
            pidx8 = grant_idx8;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pv5 = 1'b0;
        end else begin
            if (grant_v5) begin
                chk("grant5_range", int'(grant_idx5 < 3'd5), 1);
            end
            if (grant_v5 && !pv5) begin
                if (q5.size() == 0) begin
                    chk("grant5_unexpected", int'(grant_idx5), -1);
                end else begin
                    chk("grant5_idx", int'(grant_idx5), q5.pop_front());
                end
            end
            pv5   = grant_v5;
            pidx5 = grant_idx5;
        end
    end

    task automatic wait_v8();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (grant_v8) break;
        end
        chk("grant8_wait", int'(grant_v8), 1);
        if (!grant_v8 && q8.size() > 0) void'(q8.pop_back());
    endtask

    // mode: 0 done, 1 drop own req, 2 both, 3 done after raising all req
    task automatic grant8(input logic [7:0] r, input int exp,
                          input int hold, input int mode);
        logic [7:0] m;
        m = 8'h01 << exp;
        q8.push_back(exp);
        req8 = r;
        wait_v8();
        if (mode == 3) req8 = 8'hFF;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        if (mode != 1) done8 = 1'b1;
        if (mode == 1 || mode == 2) req8 = req8 & ~m;
        @(posedge clk);
        #1;
        done8 = 1'b0;
    endtask

    task automatic grant5(input logic [4:0] r, input int exp);
        q5.push_back(exp);
        req5 = r;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (grant_v5) break;
        end
        chk("grant5_wait", int'(grant_v5), 1);
        if (!grant_v5 && q5.size() > 0) void'(q5.pop_back());
        done5 = 1'b1;
        @(posedge clk);
        #1;
        done5 = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #5;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        req8   = '0;
        done8  = 1'b0;
        req5   = '0;
        done5  = 1'b0;
        #3;
        chk("rst_v8", int'(grant_v8), 0);
        chk("rst_idx8", int'(grant_idx8), 0);
        chk("rst_v5", int'(grant_v5), 0);
        chk("rst_idx5", int'(grant_idx5), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // single requester, then ptr=4 seen via full request
        grant8(8'h08, 3, 2, 0);
        req8 = '0;
        grant8(8'hFF, 4, 0, 0);
        req8 = '0;

        // rotation from ptr=0
        pulse_rst();
        for (int i = 0; i < 9; i++) begin
            grant8(8'hFF, i % 8, 0, 0);
        end
        req8 = '0;

        // wrap and skip
        grant8(8'h20, 5, 0, 0);
        grant8(8'h41, 6, 0, 0);
        grant8(8'h41, 0, 0, 0);
        grant8(8'h40, 6, 0, 0);
        grant8(8'h01, 0, 1, 0);
        req8 = '0;

        // other bits ignored, implicit and simultaneous releases
        grant8(8'h02, 1, 2, 3);
        grant8(8'h04, 2, 1, 1);
        grant8(8'h08, 3, 1, 2);
        @(posedge clk);
        #1;
        grant8(8'hFF, 4, 0, 0);
        req8 = '0;

        // reset mid-grant
        q8.push_back(5);
        req8 = 8'h20;
        wait_v8();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_v8", int'(grant_v8), 0);
        chk("midrst_idx8", int'(grant_idx8), 0);
        req8 = '0;
        #4;
        rst = 1'b0;
        grant8(8'hFF, 0, 0, 0);
        req8 = '0;

        // non-power-of-two rotation
        for (int i = 0; i < 10; i++) begin
            grant5(5'h1F, i % 5);
        end
        req5 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("q8_empty", q8.size(), 0);
        chk("q5_empty", q5.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that selects one of `NUM_REQ` requesters and presents the winner as a registered binary index plus valid. It sits directly upstream of the binary-to-one-hot decoder stage: `grant_idx`/`grant_v` connect straight to that stage's index/valid inputs, which regenerate the one-hot grant vector one cycle later. A grant is held until the owner releases it, so the downstream one-hot grant is stable for the whole transaction.

## Interface

Parameters:
- `NUM_REQ`, default 8: number of requesters, ≥2, need not be a power of two.
- `IDX_W`, default `$clog2(NUM_REQ)`: index width. Derived; do not override.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  `NUM_REQ`  request vector; bit i high means requester i wants the resource; level-sensitive.
- `done`  in  1  single-cycle release pulse from the current owner.
- `grant_idx`  out  `IDX_W`  registered index of the current owner.
- `grant_v`  out  1  registered; high while `grant_idx` names a valid owner.

## Operation

- Two states:
  - IDLE: `grant_v` = 0.
  - GRANT: `grant_v` = 1.
- Priority pointer `ptr`, `IDX_W` bits, internal.
  - It holds the index with the highest priority for the next arbitration.
- Reset values: state IDLE, `grant_v` = 0, `grant_idx` = 0, `ptr` = 0.
- IDLE with `req` = 0: remain in IDLE; `grant_idx` holds its last value.
- IDLE with `req` ≠ 0: the winner is the first set bit found scanning `ptr`, `ptr`+1, …, `NUM_REQ`-1, 0, …, `ptr`-1.
  - Register the winner into `grant_idx`, set `grant_v` = 1, go to GRANT.
- GRANT releases when `done` = 1 or `req[grant_idx]` = 0 is sampled. On release:
  - `grant_v` ← 0.
  - `ptr` ← `grant_idx`+1, wrapping from `NUM_REQ`-1 to 0, not to 2^`IDX_W`.
  - State → IDLE.
  - `grant_idx` holds its value.
- GRANT without release: all outputs hold. Changes to other `req` bits are ignored.
- `done` while in IDLE is ignored.
- `done` and a `req[grant_idx]` drop in the same cycle count as one release.
- `grant_idx` is never ≥ `NUM_REQ`. Arithmetic on `ptr` and the scan index is modulo `NUM_REQ`.
- Fairness: with all requesters continuously asserting and releasing, each requester is granted exactly once per `NUM_REQ` grants.
- `rst` asserted in any state forces the reset values immediately, independent of `clk`.
  - A grant in progress is dropped; no release bookkeeping is performed, so `ptr` returns to 0.

## Timing

- Arbitration latency: `req` sampled at edge k in IDLE → `grant_v` = 1 with a valid `grant_idx` after edge k.
- Release latency: release sampled at edge m → `grant_v` = 0 after edge m.
- Mandatory gap: the earliest next grant is after edge m+1, so `grant_v` is low for at least one full cycle between grants.
  - This guarantees the downstream decoder emits an all-zero cycle between owners.
- `grant_idx` changes only on an IDLE→GRANT transition, never while `grant_v` = 1.
- Sustained throughput: one grant per 2 cycles, when each owner releases on its first GRANT cycle.
- `req` and `done` are synchronous to `clk`; no synchronizers are included.
- Deassertion of `rst` is expected to be synchronized externally.

## Test plan

- Single requester, `NUM_REQ`=8: `req`=0x08 at edge 1 → `grant_v`=1, `grant_idx`=3 after edge 1. Pulse `done` at edge 4 → `grant_v`=0 after edge 4, `ptr`=4.
- Rotation: `req`=0xFF held, `done` pulsed each GRANT cycle → `grant_idx` sequence 0,1,2,…,7,0, each grant separated by one `grant_v`=0 cycle.
- Wrap and skip: `ptr`=6 (set by a prior grant to 5), `req`=0x41 → `grant_idx`=6; after release, next `grant_idx`=0. `req`=0x01 with `ptr`=7 → `grant_idx`=0.
- Non-power-of-two, `NUM_REQ`=5: `req`=0x1F, rotate 10 grants → sequence 0..4,0..4; `grant_idx` never 5, 6 or 7.
- Implicit release and simultaneous events: owner 2 drops `req[2]` with `done`=0 → release. Owner 3 drops `req[3]` and pulses `done` in the same cycle → exactly one release, `ptr`=4.
- Reset mid-grant: `grant_v`=1, `grant_idx`=5, assert `rst` between edges → `grant_v`=0 and `grant_idx`=0 immediately. After deassert with `req`=0xFF → `grant_idx`=0.
